mul256_serial: RTL and testbench



---
 rtl/mul256_serial.sv | 65 ++++++
 tb/tb_mul256_serial.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mul256_serial.sv
// mul256_serial: digit-serial 256x256 unsigned multiplier, MSD-first Horner accumulation
module mul256_serial #(
    parameter int DIGIT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] A,
    input  logic [255:0] B,
    output logic         busy,
    output logic         done,
    output logic [511:0] P
);
    localparam int NDIG = 256 / DIGIT_W;
    localparam int CW = $clog2(NDIG + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_d;
    logic [511:0] acc;
    logic [255:0] opa, opb;
    logic [CW-1:0] cnt;
    logic load, step, fin, last;
    logic [255+DIGIT_W:0] pp;
    assign last = cnt == CW'(NDIG - 1);
    assign pp = {{DIGIT_W{1'b0}}, opa} * {256'b0, opb[255 -: DIGIT_W]};
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_d;
    // next state: one pass through RUN per digit, then a single FIN cycle
    always_comb
        state_d = state == IDLE ? (start ? RUN : IDLE) :
                  state == RUN  ? (last ? FIN : RUN) : IDLE;
    // control decode
    always_comb begin
        load = state == IDLE && start;
        step = state == RUN;
        fin  = state == FIN;
    end
    // datapath and registered outputs; P only moves at FIN so it holds between results
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            opa  <= '0;
            opb  <= '0;
            acc  <= '0;
            cnt  <= '0;
            P    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            if (load) begin
                opa <= A;
                opb <= B;
                acc <= '0;
                cnt <= '0;
            end
            if (step) begin
                acc <= (acc << DIGIT_W) + {{(256 - DIGIT_W){1'b0}}, pp};
                opb <= opb << DIGIT_W;
                cnt <= cnt + CW'(1);
            end
            if (fin) P <= acc;
            busy <= load | (busy & ~fin);
            done <= fin;
        end
endmodule

// File: tb/tb_mul256_serial.sv
// tb_mul256_serial: scoreboard bench running all four digit widths side by side
module tb_mul256_serial;
    logic clk = 1'b0;
    logic rst, start;
    logic [255:0] a, b;
    logic [511:0] exp_p;
    int n_vec = 0;
    int n_bad = 0;
    event fin_ev;
    localparam logic [255:0] ONES = {256{1'b1}};
    localparam logic [255:0] PM1 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2E;
    always #5 clk = ~clk;
    task automatic check(string nm, int w, logic [511:0] act, logic [511:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            if (n_bad <= 20) $display("FAIL %s w=%0d got %h want %h", nm, w, act, want);
        end
    endtask
    function automatic logic [511:0] mul(logic [255:0] x, logic [255:0] y);
        return {256'b0, x} * {256'b0, y};
    endfunction
    for (genvar g = 0; g < 4; g++) begin : gw
        localparam int DW = 8 << g;
        localparam int ND = 256 / DW;
        logic busy_w, done_w;
        logic [511:0] p_w;
        logic [511:0] sb [8];
        int wr, rd, rem;
        logic m_done;
        logic [511:0] m_p;
        mul256_serial #(.DIGIT_W(DW)) dut (
            .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
            .busy(busy_w), .done(done_w), .P(p_w)
        );
        // model: accept when idle, push the expected product, done after ND+1 more edges
        always @(posedge clk or posedge rst)
            if (rst) begin
                wr = 0;
                rem = 0;
                m_done = 1'b0;
            end else begin
                m_done = 1'b0;
                if (rem > 0) begin
                    rem = rem - 1;
                    m_done = rem == 0;
                end else if (start) begin
                    sb[wr % 8] = exp_p;
                    wr = wr + 1;
                    rem = ND + 1;
                end
            end
        // monitor: pop on done, check handshake and held result every cycle
        always @(negedge clk)
            if (rst) begin
                rd = 0;
                m_p = '0;
            end else begin
                check("busy", DW, 512'(busy_w), 512'(rem > 0));
                check("done", DW, 512'(done_w), 512'(m_done));
                if (done_w) begin
                    check("pending", DW, 512'(wr > rd), 512'(1));
                    if (wr > rd) begin
                        m_p = sb[rd % 8];
                        rd = rd + 1;
                    end
                end
                check("P", DW, p_w, m_p);
            end
        always @(posedge rst) begin
            #1;
            check("rst_busy", DW, 512'(busy_w), 512'(0));
            check("rst_done", DW, 512'(done_w), 512'(0));
            check("rst_P", DW, p_w, 512'(0));
        end
        always @(fin_ev) check("drained", DW, 512'(wr - rd), 512'(0));
    end
    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic op(logic [255:0] x, logic [255:0] y, logic [511:0] e);
        a = x;
        b = y;
        exp_p = e;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(36);
    endtask
    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        exp_p = '0;
        cyc(3);
        rst = 1'b0;
        cyc(5);
        op(256'h1234, 256'h10000, 512'h12340000);
        op(ONES, ONES, {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1});
        op('0, ONES, '0);
        op({1'b1, 255'b0}, 256'd2, {255'b0, 1'b1, 256'b0});
        op(PM1, PM1, mul(PM1, PM1));
        a = 256'hCAFE;
        b = 256'h1_0000;
        exp_p = 512'hCAFE0000;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        a = 256'h7;
        b = 256'h9;
        exp_p = 512'h3F;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        a = 256'h55;
        b = 256'h66;
        exp_p = 512'h21DE;
        cyc(36);
        a = 256'hDEADBEEF << 100;
        b = 256'h1_0000_0001;
        exp_p = mul(256'hDEADBEEF << 100, 256'h1_0000_0001);
        start = 1'b1;
        cyc(3 * 34);
        start = 1'b0;
        cyc(36);
        a = ONES;
        b = 256'h1234_5678;
        exp_p = mul(ONES, 256'h1234_5678);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(6);
        #3;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(40);
        op(256'd3, 256'd5, 512'd15);
        -> fin_ev;
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
